dmem_responder: RTL

Data-memory responder for the pipelined RV32 core: the target end of the core's load/store port. It accepts one request at a time through a valid/ready handshake and performs byte, half or word stores with lane merging. Loads return sign- or zero-extended data after a fixed, parameterised latency. It sits beside the core at SoC level and can insert wait states, so the hazard unit's stall path is exercised under memory back-pressure.

---
 rtl/dmem_if.sv | 24 ++
 rtl/dmem_responder.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_if.sv
// Load/store port bundle between the core (master) and dmem_responder (slave).
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding request, lane-merged stores, extended loads
// after LATENCY cycles. Define DMEM_ERR_EN to enable alignment/size/range faults.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic   clk,
    input  logic   reset,
    dmem_if.slave  bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'((LATENCY >= 2) ? (LATENCY - 2) : 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    off_q, off_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic          we_q, we_d;
    logic          err_q, err_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;

    logic [31:0]   mem [0:DEPTH_WORDS-1];
    logic [31:0]   hold_q;

    logic          accept;
    logic          req_fault;
    logic [AW-1:0] word_idx;
    logic [3:0]    be;
    logic [31:0]   wdata_rep;
    logic [7:0]    hold_bytes [4];
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   load_data;

    assign accept   = bus.req_valid && (state_q == IDLE);
    assign word_idx = bus.req_addr[AW+1:2];

`ifdef DMEM_ERR_EN
    assign req_fault = (bus.req_size == 2'b11)
                    || (bus.req_size == 2'b01 && bus.req_addr[0])
                    || (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00)
                    || ((bus.req_addr >> (AW + 2)) != 32'd0);
`else
    // Upper address bits are discarded so the index wraps; keep them visibly consumed.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.req_addr;
    assign req_fault = 1'b0;
`endif

    always_comb begin
        be        = 4'b1111;
        wdata_rep = bus.req_wdata;
        case (bus.req_size)
            2'b00: begin
                be        = 4'b0001 << bus.req_addr[1:0];
                wdata_rep = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                be        = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{bus.req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Array and holding register carry no reset so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (bus.req_we && !req_fault) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) mem[word_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
                end
            end
            hold_q <= mem[word_idx];
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign hold_bytes[gi] = hold_q[8*gi +: 8];
    end

    assign byte_sel = hold_bytes[off_q];
    assign half_sel = off_q[1] ? hold_q[31:16] : hold_q[15:0];

    always_comb begin
        case (size_q)
            2'b00:   load_data = {{24{~uns_q & byte_sel[7]}}, byte_sel};
            2'b01:   load_data = {{16{~uns_q & half_sel[15]}}, half_sel};
            default: load_data = hold_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        off_d       = off_q;
        size_d      = size_q;
        uns_d       = uns_q;
        we_d        = we_q;
        err_d       = err_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    off_d  = bus.req_addr[1:0];
                    size_d = bus.req_size;
                    uns_d  = bus.req_unsigned;
                    we_d   = bus.req_we;
                    err_d  = req_fault;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) state_d = RESP;
                else             cnt_d   = cnt_q - 1'b1;
            end
            RESP: begin
                // First RESP cycle registers the response; it then holds until taken.
                if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = (we_q || err_q) ? 32'd0 : load_data;
                    rsp_err_d   = err_q;
                end else if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            off_q       <= 2'b00;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            off_q       <= off_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            we_q        <= we_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
`ifdef DMEM_ERR_EN
    assign bus.rsp_err   = rsp_err_q;
`else
    logic unused_rsp_err;
    assign unused_rsp_err = rsp_err_q;
    assign bus.rsp_err    = 1'b0;
`endif
endmodule
